// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_if
// Description : Bundles the result-source handshakes, the register file write
//               port and the hazard query port of wb_write_arbiter.
//   slave  modport : the arbiter side (consumes results, drives write port)
//   master modport : the environment side (ALU, MDU, issue logic, regfile)
//   Signals:
//     alu_valid/alu_addr/alu_data/alu_stall  single-cycle ALU/load result path
//     mdu_valid/mdu_ready/mdu_addr/mdu_data  MDU result valid/ready handshake
//     write_enable/address_d/data_dval       register file write port
//     query_addr/query_pending               pending-write hazard query
//     fifo_count                             MDU FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                          alu_valid;
    logic [4:0]                    alu_addr;
    logic [31:0]                   alu_data;
    logic                          alu_stall;
    logic                          mdu_valid;
    logic                          mdu_ready;
    logic [4:0]                    mdu_addr;
    logic [31:0]                   mdu_data;
    logic                          write_enable;
    logic [4:0]                    address_d;
    logic [31:0]                   data_dval;
    logic [4:0]                    query_addr;
    logic                          query_pending;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  query_addr,
        output alu_stall, mdu_ready,
        output write_enable, address_d, data_dval,
        output query_pending, fifo_count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mdu_valid, mdu_addr, mdu_data,
        output query_addr,
        input  alu_stall, mdu_ready,
        input  write_enable, address_d, data_dval,
        input  query_pending, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Writeback arbiter for the single register file write port.
//               ALU/load results have priority; MDU results are buffered in a
//               FIFO and drained when the ALU is idle, or forced through after
//               STARVE_LIMIT consecutive blocking ALU writes (ALU is stalled).
//               Writes to register 0 are dropped. A combinational query tells
//               the issue logic whether a register has a buffered MDU write.
//   Ports:
//     clock    : system clock, all state on posedge
//     reset_n  : synchronous active-low reset
//     bus      : wb_write_arbiter_if.slave (ALU, MDU, write port, query)
//   Parameters:
//     FIFO_DEPTH   : MDU FIFO entries, power of two 2..16
//     STARVE_LIMIT : blocked cycles before the FIFO is forced through, 1..15
//   Optional feature (macro WB_TRACE_EN): prints every register file write and
//     every MDU push refused while full. Undefined: no simulation output.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    wb_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [3:0]    C_LIMIT = 4'(STARVE_LIMIT);

    // FIFO storage (no reset needed: validity comes from head/count)
    logic [4:0]    addr_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_q [FIFO_DEPTH];

    logic [PW-1:0] head_q,  head_d;
    logic [PW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    starve_q, starve_d;
    logic          we_q,    we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic w_nonempty, w_ready, w_stall, w_alu_acc, w_pop, w_push;

    assign w_nonempty = (count_q != '0);
    assign w_ready    = (count_q < C_DEPTH);
    assign w_stall    = (starve_q == C_LIMIT) && w_nonempty;
    assign w_alu_acc  = bus.alu_valid && !w_stall;
    assign w_pop      = !w_alu_acc && w_nonempty;
    // Register-0 results complete the handshake but never occupy an entry
    assign w_push     = bus.mdu_valid && w_ready && (bus.mdu_addr != 5'd0);

    always_comb begin
        head_d   = w_pop  ? head_q + PW'(1) : head_q;
        tail_d   = w_push ? tail_q + PW'(1) : tail_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Only ALU writes that actually block a waiting FIFO count as starving
        starve_d = starve_q;
        if (w_pop)
            starve_d = '0;
        else if (w_alu_acc && w_nonempty && (starve_q != C_LIMIT))
            starve_d = starve_q + 4'd1;

        we_d    = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        if (w_alu_acc) begin
            we_d    = (bus.alu_addr != 5'd0);
            waddr_d = bus.alu_addr;
            wdata_d = bus.alu_data;
        end else if (w_pop) begin
            we_d    = 1'b1;
            waddr_d = addr_mem_q[head_q];
            wdata_d = data_mem_q[head_q];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            addr_mem_q[tail_q] <= bus.mdu_addr;
            data_mem_q[tail_q] <= bus.mdu_data;
        end
    end

    // Hazard query: an entry is live when its distance from head is below count.
    // The popped entry has already left the FIFO once it sits on the write port.
    logic [PW-1:0]         w_off [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] w_hit;

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
        assign w_off[gi] = PW'(gi) - head_q;
        assign w_hit[gi] = ({1'b0, w_off[gi]} < count_q) &&
                           (addr_mem_q[gi] == bus.query_addr);
    end

    assign bus.query_pending = (|w_hit) && (bus.query_addr != 5'd0);
    assign bus.alu_stall     = w_stall;
    assign bus.mdu_ready     = w_ready;
    assign bus.fifo_count    = count_q;
    assign bus.write_enable  = we_q;
    assign bus.address_d     = waddr_q;
    assign bus.data_dval     = wdata_q;

`ifdef WB_TRACE_EN
    logic [31:0] cycle_q;
    logic        src_mdu_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            src_mdu_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_q + 32'd1;
            src_mdu_q <= w_pop;
            if (we_q)
                $display("[wb_trace] cycle %0d %s x%0d <= %h",
                         cycle_q, src_mdu_q ? "MDU" : "ALU", waddr_q, wdata_q);
            if (bus.mdu_valid && !w_ready)
                $display("[wb_trace] cycle %0d MDU push refused (full) x%0d %h",
                         cycle_q, bus.mdu_addr, bus.mdu_data);
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Self-checking bench for wb_write_arbiter. Inputs are applied on
//               the falling edge; outputs are sampled 4 ns later, before the
//               next rising edge. Each table row lists the inputs of one cycle
//               and the outputs expected during that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;
    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_err    = 0;

    wb_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();

    wb_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        av;  logic [4:0] aa;  logic [31:0] ad;
        logic        mv;  logic [4:0] ma;  logic [31:0] md;
        logic [4:0]  qa;
        logic        we;  logic [4:0] wa;  logic [31:0] wd;
        logic        st;  logic       rd;  logic [2:0]  cnt; logic qp;
    } vec_t;

    function automatic vec_t mk(
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic [4:0] qa,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic st, input logic rd, input logic [2:0] cnt, input logic qp);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.qa = qa; v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.rd = rd;
        v.cnt = cnt; v.qp = qp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rn,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] qa);
        @(negedge clock);
        reset_n        = rn;
        bus.alu_valid  = av;
        bus.alu_addr   = aa;
        bus.alu_data   = ad;
        bus.mdu_valid  = mv;
        bus.mdu_addr   = ma;
        bus.mdu_data   = md;
        bus.query_addr = qa;
        #4;
    endtask

    // Fill to full with the ALU busy, see the forced pop refuse a push,
    // accept it next cycle, then drain and verify write order.
    task automatic run_round(input int r);
        logic [4:0]  got_a[$];
        logic [31:0] got_d[$];
        for (int c = 0; c < 12; c++) begin
            int          k;
            logic        act;
            logic [31:0] md;
            k   = (c < 4) ? c : 4;
            act = (c <= 5);
            md  = 32'hC000_0000 | (32'(r) << 8) | 32'(k);
            drive(1'b1, act, 5'd8, 32'h8888_0000 + 32'(c), act, 5'(10 + k), md, 5'd0);
            if (bus.write_enable && bus.address_d != 5'd8) begin
                got_a.push_back(bus.address_d);
                got_d.push_back(bus.data_dval);
            end
            if (c == 4) begin
                chk($sformatf("r%0d full ready", r), 32'(bus.mdu_ready), 32'd0);
                chk($sformatf("r%0d full stall", r), 32'(bus.alu_stall), 32'd1);
                chk($sformatf("r%0d full count", r), 32'(bus.fifo_count), 32'd4);
            end
            if (c == 5) begin
                chk($sformatf("r%0d after pop ready", r), 32'(bus.mdu_ready), 32'd1);
                chk($sformatf("r%0d after pop count", r), 32'(bus.fifo_count), 32'd3);
            end
            if (c == 11)
                chk($sformatf("r%0d drained count", r), 32'(bus.fifo_count), 32'd0);
        end
        chk($sformatf("r%0d write count", r), 32'(got_a.size()), 32'd5);
        for (int k = 0; k < 5 && k < got_a.size(); k++) begin
            chk($sformatf("r%0d w%0d addr", r, k), 32'(got_a[k]), 32'(10 + k));
            chk($sformatf("r%0d w%0d data", r, k), got_d[k],
                32'hC000_0000 | (32'(r) << 8) | 32'(k));
        end
    endtask

    initial begin
        vec_t vecs[$];
        // Test 1: single MDU result, ALU idle
        vecs.push_back(mk(0,0,0,           1,5,32'h1111_0005, 5, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 0,0,0,               0,1,1,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,5,32'h1111_0005,   0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 0,0,0,               0,1,0,0));
        // Test 3: register 0 from both sources, then a normal ALU write
        vecs.push_back(mk(1,0,32'hDEAD_BEEF,1,0,32'h1,        0, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             0, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(1,9,32'h99,      0,0,0,             0, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             0, 1,9,32'h99,          0,1,0,0));
        // Test 2: ALU held on reg 8 while 4 MDU results queue; starvation stall
        vecs.push_back(mk(1,8,32'h8000_0000,1,1,32'h101,      1, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(1,8,32'h8000_0001,1,2,32'h102,      1, 1,8,32'h8000_0000,   0,1,1,1));
        vecs.push_back(mk(1,8,32'h8000_0002,1,3,32'h103,      1, 1,8,32'h8000_0001,   0,1,2,1));
        vecs.push_back(mk(1,8,32'h8000_0003,1,4,32'h104,      1, 1,8,32'h8000_0002,   0,1,3,1));
        vecs.push_back(mk(1,8,32'h8000_0004,1,5,32'h105,      1, 1,8,32'h8000_0003,   1,0,4,1));
        vecs.push_back(mk(1,8,32'h8000_0004,1,5,32'h105,      1, 1,1,32'h101,         0,1,3,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,8,32'h8000_0004,   0,0,4,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,2,32'h102,         0,1,3,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,3,32'h103,         0,1,2,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,4,32'h104,         0,1,1,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 1,5,32'h105,         0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             5, 0,0,0,               0,1,0,0));
        // Test 4: two results for reg 7, written in push order
        vecs.push_back(mk(0,0,0,           1,7,32'hA,         7, 0,0,0,               0,1,0,0));
        vecs.push_back(mk(0,0,0,           1,7,32'hB,         7, 0,0,0,               0,1,1,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             7, 1,7,32'hA,           0,1,1,1));
        vecs.push_back(mk(0,0,0,           0,0,0,             7, 1,7,32'hB,           0,1,0,0));
        vecs.push_back(mk(0,0,0,           0,0,0,             0, 0,0,0,               0,1,0,0));

        // Reset state
        drive(1'b0, 0, 0, 0, 0, 0, 0, 5'd5);
        drive(1'b0, 0, 0, 0, 0, 0, 0, 5'd5);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 5'd5);
        chk("rst we",    32'(bus.write_enable),  32'd0);
        chk("rst addr",  32'(bus.address_d),     32'd0);
        chk("rst data",  bus.data_dval,          32'd0);
        chk("rst stall", 32'(bus.alu_stall),     32'd0);
        chk("rst ready", 32'(bus.mdu_ready),     32'd1);
        chk("rst count", 32'(bus.fifo_count),    32'd0);
        chk("rst qp",    32'(bus.query_pending), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(1'b1, v.av, v.aa, v.ad, v.mv, v.ma, v.md, v.qa);
            chk($sformatf("v%0d we", i),    32'(bus.write_enable),  32'(v.we));
            chk($sformatf("v%0d stall", i), 32'(bus.alu_stall),     32'(v.st));
            chk($sformatf("v%0d ready", i), 32'(bus.mdu_ready),     32'(v.rd));
            chk($sformatf("v%0d count", i), 32'(bus.fifo_count),    32'(v.cnt));
            chk($sformatf("v%0d qp", i),    32'(bus.query_pending), 32'(v.qp));
            if (v.we) begin
                chk($sformatf("v%0d addr", i), 32'(bus.address_d), 32'(v.wa));
                chk($sformatf("v%0d data", i), bus.data_dval,      v.wd);
            end
        end

        // Test 5: three full refill rounds, pointers wrap
        for (int r = 0; r < 3; r++)
            run_round(r);

        // Test 6: reset with 3 entries queued and a write in flight
        drive(1'b1, 1, 5'd8, 32'h77, 1, 5'd20, 32'h20, 5'd21);
        drive(1'b1, 1, 5'd8, 32'h78, 1, 5'd21, 32'h21, 5'd21);
        drive(1'b1, 1, 5'd8, 32'h79, 1, 5'd22, 32'h22, 5'd21);
        chk("t6 pre count", 32'(bus.fifo_count),   32'd2);
        chk("t6 pre we",    32'(bus.write_enable), 32'd1);
        drive(1'b0, 1, 5'd8, 32'h7A, 0, 5'd0, 32'h0, 5'd21);
        chk("t6 q3 count",  32'(bus.fifo_count),    32'd3);
        chk("t6 q3 we",     32'(bus.write_enable),  32'd1);
        chk("t6 q3 qp",     32'(bus.query_pending), 32'd1);
        drive(1'b1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd21);
        chk("t6 rst we",    32'(bus.write_enable),  32'd0);
        chk("t6 rst count", 32'(bus.fifo_count),    32'd0);
        chk("t6 rst qp",    32'(bus.query_pending), 32'd0);
        chk("t6 rst addr",  32'(bus.address_d),     32'd0);
        chk("t6 rst data",  bus.data_dval,          32'd0);
        chk("t6 rst stall", 32'(bus.alu_stall),     32'd0);
        chk("t6 rst ready", 32'(bus.mdu_ready),     32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
